// File: rtl/aibcr3aux_osc_divbyn_pkg.sv
// Shared constants and helpers for the aux oscillator divider.
package aibcr3aux_osc_pkg;

    localparam int unsigned DIVHP_MIN    = 1;
    localparam int unsigned NUM_TAPS_MAX = 8;

    // Whether the state flops load from the scan chain or run normally.
    typedef enum logic {
        OP_FUNC  = 1'b0,
        OP_SHIFT = 1'b1
    } scan_op_e;

    // Scan chain length: taps, out_prog, prog_cnt, active_hp, div_busy.
    function automatic int unsigned scan_len(input int unsigned num_taps,
                                             input int unsigned cnt_w);
        return num_taps + 1 + 2 * cnt_w + 1;
    endfunction

endpackage

// File: rtl/aibcr3aux_osc_divbyn_if.sv
// Ratio control and status bundle between a clock consumer and the divider.
interface aibcr3aux_osc_divbyn_if #(
    parameter int unsigned CNT_W = 8
);
    logic             div_en;
    logic [CNT_W-1:0] div_hp;
    logic             div_load;
    logic             div_busy;
    logic             div_ack;

    modport master (
        output div_en, div_hp, div_load,
        input  div_busy, div_ack
    );

    modport slave (
        input  div_en, div_hp, div_load,
        output div_busy, div_ack
    );
endinterface

// File: rtl/aibcr3aux_osc_divbyn_prog.sv
// Programmable even-ratio divider with glitch-free ratio change and stop.
module aibcr3aux_osc_divbyn_prog
    import aibcr3aux_osc_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic               clkin,
    input  logic               por,
    input  logic               div_en,
    input  logic [CNT_W-1:0]   div_hp,
    input  logic               div_load,
    input  logic               shift_en,
    input  logic [2*CNT_W+1:0] scan_d,
    output logic [2*CNT_W+1:0] scan_q,
    output logic               out_prog,
    output logic               div_busy,
    output logic               div_ack
);

    localparam logic [CNT_W-1:0] HP_ONE = CNT_W'(DIVHP_MIN);

    logic [CNT_W-1:0] prog_cnt;
    logic [CNT_W-1:0] active_hp;
    logic [CNT_W-1:0] pending_hp;
    logic [CNT_W-1:0] hp_clamped;
    logic             count_en;
    logic             at_term;
    logic             apply;

    // Chain order within this slice: out_prog first, div_busy last.
    assign scan_q     = {div_busy, active_hp, prog_cnt, out_prog};

    assign hp_clamped = (div_hp < HP_ONE) ? HP_ONE : div_hp;
    // A high phase always runs to completion, even after div_en drops.
    assign count_en   = div_en | out_prog;
    assign at_term    = (prog_cnt == (active_hp - CNT_W'(1)));
    // Ratio swaps only on the falling toggle, so no phase is ever cut short.
    assign apply      = count_en & at_term & out_prog & div_busy;

    // Phase counter, output toggle, pending/active ratio and ack pulse.
    always_ff @(posedge clkin or posedge por) begin
        if (por) begin
            prog_cnt   <= '0;
            out_prog   <= 1'b0;
            active_hp  <= HP_ONE;
            pending_hp <= '0;
            div_busy   <= 1'b0;
            div_ack    <= 1'b0;
        end else if (shift_en) begin
            {div_busy, active_hp, prog_cnt, out_prog} <= scan_d;
            div_ack <= 1'b0;
        end else begin
            div_ack <= apply;
            if (!count_en) begin
                prog_cnt <= '0;
            end else if (at_term) begin
                prog_cnt <= '0;
                out_prog <= ~out_prog;
            end else begin
                prog_cnt <= prog_cnt + CNT_W'(1);
            end
            if (apply) begin
                active_hp <= pending_hp;
            end
            // A load coinciding with apply keeps busy set for the new value.
            if (div_load) begin
                pending_hp <= hp_clamped;
                div_busy   <= 1'b1;
            end else if (apply) begin
                div_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/aibcr3aux_osc_divbyn.sv
// Aux oscillator divider: power-of-two taps, programmable output, scan chain.
module aibcr3aux_osc_divbyn
    import aibcr3aux_osc_pkg::*;
#(
    parameter int unsigned NUM_TAPS = 3,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                         clkin,
    input  logic                         por,
    aibcr3aux_osc_divbyn_if.slave        div_if,
    output logic [NUM_TAPS-1:0]          out_tap,
    output logic                         out_prog,
    input  logic                         scan_mode_n,
    input  logic                         scan_shift_n,
    input  logic                         scan_in,
    output logic                         scan_out
);

    localparam int unsigned CHAIN_LEN = scan_len(NUM_TAPS, CNT_W);
    localparam int unsigned PROG_LEN  = CHAIN_LEN - NUM_TAPS;

    scan_op_e              scan_op;
    logic                  shift_en;
    logic [NUM_TAPS-1:0]   tap_cnt;
    logic [PROG_LEN-1:0]   prog_q;
    logic [CHAIN_LEN-1:0]  chain_q;
    logic [CHAIN_LEN-1:0]  chain_d;

    assign scan_op  = (!scan_mode_n && !scan_shift_n) ? OP_SHIFT : OP_FUNC;
    assign shift_en = (scan_op == OP_SHIFT);

    // Whole chain as one vector: tap_cnt[0] nearest scan_in, div_busy at the end.
    assign chain_q  = {prog_q, tap_cnt};
    assign chain_d  = {chain_q[CHAIN_LEN-2:0], scan_in};
    assign scan_out = chain_q[CHAIN_LEN-1];
    assign out_tap  = tap_cnt;

    // Free-running tap counter, frozen while div_en is low.
    always_ff @(posedge clkin or posedge por) begin
        if (por) begin
            tap_cnt <= '0;
        end else if (shift_en) begin
            tap_cnt <= chain_d[NUM_TAPS-1:0];
        end else if (div_if.div_en) begin
            tap_cnt <= tap_cnt + NUM_TAPS'(1);
        end
    end

    aibcr3aux_osc_divbyn_prog #(
        .CNT_W (CNT_W)
    ) u_prog (
        .clkin    (clkin),
        .por      (por),
        .div_en   (div_if.div_en),
        .div_hp   (div_if.div_hp),
        .div_load (div_if.div_load),
        .shift_en (shift_en),
        .scan_d   (chain_d[CHAIN_LEN-1:NUM_TAPS]),
        .scan_q   (prog_q),
        .out_prog (out_prog),
        .div_busy (div_if.div_busy),
        .div_ack  (div_if.div_ack)
    );

endmodule

// File: tb/tb_aibcr3aux_osc_divbyn.sv
// Directed bench for aibcr3aux_osc_divbyn (NUM_TAPS=3, CNT_W=8).
module tb_aibcr3aux_osc_divbyn;

    logic       clkin;
    logic       por;
    logic [2:0] out_tap;
    logic       out_prog;
    logic       scan_mode_n;
    logic       scan_shift_n;
    logic       scan_in;
    logic       scan_out;

    int n_assert = 0;
    int n_fail   = 0;

    logic [20:0] v1;
    logic [20:0] v2;
    logic [4:0]  cap_prog;

    aibcr3aux_osc_divbyn_if #(.CNT_W(8)) div_if ();

    aibcr3aux_osc_divbyn #(
        .NUM_TAPS (3),
        .CNT_W    (8)
    ) dut (
        .clkin        (clkin),
        .por          (por),
        .div_if       (div_if),
        .out_tap      (out_tap),
        .out_prog     (out_prog),
        .scan_mode_n  (scan_mode_n),
        .scan_shift_n (scan_shift_n),
        .scan_in      (scan_in),
        .scan_out     (scan_out)
    );

    initial begin
        clkin = 1'b0;
        forever #5 clkin = ~clkin;
    end

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic stp(input string tag, input logic p, input logic b, input logic a);
        tick();
        chk({tag, "_prog"}, 32'(out_prog), 32'(p));
        chk({tag, "_busy"}, 32'(div_if.div_busy), 32'(b));
        chk({tag, "_ack"},  32'(div_if.div_ack), 32'(a));
    endtask

    // p/b/a hold expected out_prog/div_busy/div_ack, bit i for step i.
    task automatic seq(input string tag, input int n, input logic [31:0] p,
                       input logic [31:0] b, input logic [31:0] a);
        for (int i = 0; i < n; i++) begin
            stp($sformatf("%s[%0d]", tag, i), p[i], b[i], a[i]);
        end
    endtask

    initial begin
        por             = 1'b0;
        div_if.div_en   = 1'b0;
        div_if.div_hp   = 8'd0;
        div_if.div_load = 1'b0;
        scan_mode_n     = 1'b1;
        scan_shift_n    = 1'b1;
        scan_in         = 1'b0;
        #2 por = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_tap",  32'(out_tap), 32'd0);
        chk("rst_prog", 32'(out_prog), 32'd0);
        chk("rst_busy", 32'(div_if.div_busy), 32'd0);
        chk("rst_ack",  32'(div_if.div_ack), 32'd0);
        chk("rst_sout", 32'(scan_out), 32'd0);

        // Taps and default divide-by-2
        por           = 1'b0;
        div_if.div_en = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            tick();
            chk($sformatf("tap[%0d]", i), 32'(out_tap), 32'(i % 8));
            chk($sformatf("hp1_prog[%0d]", i), 32'(out_prog), 32'(i % 2));
            chk($sformatf("hp1_ack[%0d]", i), 32'(div_if.div_ack), 32'd0);
        end

        // Ratio change to hp=3 requested during a high phase
        tick();
        chk("hi_before_load", 32'(out_prog), 32'd1);
        div_if.div_hp   = 8'd3;
        div_if.div_load = 1'b1;
        stp("ld3", 1'b0, 1'b1, 1'b0);
        div_if.div_load = 1'b0;
        seq("hp3", 14, 32'b01110001110001, 32'b00000000000001, 32'b00000000000010);

        // Load 0 then 5 back to back: one apply, period 10
        div_if.div_hp   = 8'd0;
        div_if.div_load = 1'b1;
        stp("ld0a", 1'b0, 1'b1, 1'b0);
        div_if.div_hp   = 8'd5;
        stp("ld5", 1'b0, 1'b1, 1'b0);
        div_if.div_load = 1'b0;
        seq("hp5", 20, 32'b11000001111100000111, 32'b111, 32'b1000);

        // Lone load of 0 gives divide-by-2
        div_if.div_hp   = 8'd0;
        div_if.div_load = 1'b1;
        stp("ld0b", 1'b1, 1'b1, 1'b0);
        div_if.div_load = 1'b0;
        seq("hp0", 7, 32'b0101011, 32'b0000011, 32'b0000100);

        // hp=4, then stop one cycle into the high phase, then restart
        div_if.div_hp   = 8'd4;
        div_if.div_load = 1'b1;
        stp("ld4", 1'b1, 1'b1, 1'b0);
        div_if.div_load = 1'b0;
        seq("hp4", 5, 32'b10000, 32'b0, 32'b00001);
        div_if.div_en = 1'b0;
        seq("stop", 11, 32'b00000000111, 32'b0, 32'b0);
        chk("stop_tap", 32'(out_tap), 32'd4);
        div_if.div_en = 1'b1;
        stp("restart0", 1'b0, 1'b0, 1'b0);
        chk("restart_tap", 32'(out_tap), 32'd5);
        seq("restart", 7, 32'b0111100, 32'b0, 32'b0);

        // por during a high phase with a ratio pending
        div_if.div_hp   = 8'd2;
        div_if.div_load = 1'b1;
        stp("ld2", 1'b0, 1'b1, 1'b0);
        div_if.div_load = 1'b0;
        seq("pre_por", 3, 32'b100, 32'b111, 32'b0);
        #2 por = 1'b1;
        #1;
        chk("por_prog", 32'(out_prog), 32'd0);
        chk("por_busy", 32'(div_if.div_busy), 32'd0);
        chk("por_ack",  32'(div_if.div_ack), 32'd0);
        chk("por_tap",  32'(out_tap), 32'd0);
        tick();
        chk("por_hold_prog", 32'(out_prog), 32'd0);
        por = 1'b0;
        seq("post_por", 6, 32'b010101, 32'b0, 32'b0);
        chk("post_por_tap", 32'(out_tap), 32'd6);

        // Scan shift-through, with div_en/div_load active but ignored
        v1 = 21'h15A3C6;
        v2 = {1'b0, 8'd3, 8'd1, 1'b0, 3'd6};
        scan_mode_n     = 1'b0;
        scan_shift_n    = 1'b0;
        div_if.div_hp   = 8'd9;
        div_if.div_load = 1'b1;
        for (int j = 0; j < 21; j++) begin
            scan_in = v1[20-j];
            tick();
        end
        for (int j = 0; j < 21; j++) begin
            chk($sformatf("scan_out[%0d]", j), 32'(scan_out), 32'(v1[20-j]));
            scan_in = v2[20-j];
            tick();
        end
        chk("scan_ld_tap",  32'(out_tap), 32'd6);
        chk("scan_ld_prog", 32'(out_prog), 32'd0);
        chk("scan_ld_busy", 32'(div_if.div_busy), 32'd0);

        // Capture: resume counting from the shifted-in state
        div_if.div_load = 1'b0;
        scan_shift_n    = 1'b1;
        cap_prog        = 5'b01110;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("cap_tap[%0d]", k), 32'(out_tap), 32'((7 + k) % 8));
            chk($sformatf("cap_prog[%0d]", k), 32'(out_prog), 32'(cap_prog[k]));
            chk($sformatf("cap_ack[%0d]", k), 32'(div_if.div_ack), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
